// File: rtl/uart_tx_arbiter.sv
// Four-requester arbiter feeding one UART transmitter: strobe handshake, busy timeout, sticky error.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default build is round-robin.
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  tx_din,
  output logic        tx_wr_en,
  input  logic        tx_busy,
  output logic [1:0]  grant_id,
  output logic        active,
  output logic        tx_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [1:0]  win_idx;
  logic        win_any;
  logic        grant_ok;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  assign win_any = |req_valid;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign win_idx = lowest_set(req_valid);
`else
  logic [1:0] last_q, last_d;
  logic [1:0] start_idx;
  logic [7:0] doubled;
  logic [3:0] rotated;

  // Rotate the request vector so the requester after the last winner sits at bit 0.
  assign start_idx = last_q + 2'd1;
  assign doubled   = {req_valid, req_valid} >> start_idx;
  assign rotated   = doubled[3:0];
  assign win_idx   = start_idx + lowest_set(rotated);
`endif

  // A grant is only offered from IDLE with the transmitter quiet; reset also masks it.
  assign grant_ok  = reset_n && (state_q == IDLE) && !tx_busy && win_any;
  assign req_ready = grant_ok ? (4'b0001 << win_idx) : 4'b0000;

  assign tx_wr_en  = (state_q == STROBE);
  assign active    = (state_q != IDLE);
  assign tx_din    = din_q;
  assign grant_id  = grant_q;
  assign tx_err    = err_q;

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          din_d   = req_data[{win_idx, 3'b000} +: 8];
          grant_d = win_idx;
`ifndef UART_ARB_FIXED_PRIO_EN
          last_d  = win_idx;
`endif
          cnt_d   = 4'd0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = 4'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          cnt_d   = 4'd0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          // Transmitter never acknowledged the strobe: flag it and drop the byte.
          if (cnt_d == 4'(BUSY_TIMEOUT)) begin
            err_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      din_q   <= 8'h00;
      grant_q <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      last_q  <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  a_ready_onehot : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(req_ready));
  a_strobe_single : assert property (@(posedge clock) disable iff (!reset_n)
    tx_wr_en |=> !tx_wr_en);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus hand-written corner sequences,
// with a strobe scoreboard fed when a grant is expected.
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_din;
  logic        tx_wr_en;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        tx_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } sb_t;
  sb_t sbQueue[$];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  expReady;
  } vec_t;
  vec_t vecs[8];

  logic [7:0] expByte;
  logic       prevWrEn = 1'b0;

  uart_tx_arbiter #(.BUSY_TIMEOUT(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_din    (tx_din),
    .tx_wr_en  (tx_wr_en),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .tx_err    (tx_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic busy);
    req_valid = valid;
    req_data  = data;
    tx_busy   = busy;
  endtask

  // Drive at a falling edge, check the combinational grant, and record the expected strobe.
  task automatic driveAndExpect(input logic [3:0] valid, input logic [31:0] data, input logic busy,
                                input logic [3:0] expReady, input string name);
    sb_t e;
    @(negedge clock);
    applyStimulus(valid, data, busy);
    #1;
    checkOutput(name, {28'd0, req_ready}, {28'd0, expReady});
    if (expReady != 4'd0) begin
      e.id = 2'd0;
      for (int i = 0; i < 4; i++) begin
        if (expReady[i]) e.id = 2'(i);
      end
      e.data  = data[{e.id, 3'b000} +: 8];
      expByte = e.data;
      sbQueue.push_back(e);
    end
  endtask

  // Transmitter model: busy rises in the first WAIT_BUSY cycle and stays up busyLen cycles.
  task automatic finishTransfer(input int busyLen);
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    applyStimulus(req_valid, req_data, 1'b1);
    @(negedge clock);
    checkOutput("wait_done_active", {31'd0, active}, 32'd1);
    checkOutput("hold_din", {24'd0, tx_din}, {24'd0, expByte});
    checkOutput("blocked_ready", {28'd0, req_ready}, 32'd0);
    repeat (busyLen - 1) @(negedge clock);
    applyStimulus(4'd0, req_data, 1'b0);
  endtask

  // Strobe monitor: pops the scoreboard and enforces one-hot ready and single-cycle strobes.
  always @(negedge clock) begin
    if (reset_n) begin
      checkOutput("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
      checkOutput("wr_en_double", {31'd0, prevWrEn & tx_wr_en}, 32'd0);
      if (tx_wr_en) begin
        checkOutput("strobe_expected", {31'd0, sbQueue.size() > 0}, 32'd1);
        if (sbQueue.size() > 0) begin
          sb_t e;
          e = sbQueue.pop_front();
          checkOutput("strobe_din", {24'd0, tx_din}, {24'd0, e.data});
          checkOutput("strobe_grant", {30'd0, grant_id}, {30'd0, e.id});
        end
      end
    end
    prevWrEn = tx_wr_en;
  end

  initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
    vecs[0].valid = 4'b1111; vecs[0].expReady = 4'b0001;
    vecs[1].valid = 4'b1111; vecs[1].expReady = 4'b0001;
    vecs[2].valid = 4'b1111; vecs[2].expReady = 4'b0001;
    vecs[3].valid = 4'b1111; vecs[3].expReady = 4'b0001;
    vecs[4].valid = 4'b1001; vecs[4].expReady = 4'b0001;
    vecs[5].valid = 4'b0110; vecs[5].expReady = 4'b0010;
    vecs[6].valid = 4'b0011; vecs[6].expReady = 4'b0001;
    vecs[7].valid = 4'b0100; vecs[7].expReady = 4'b0100;
`else
    vecs[0].valid = 4'b1111; vecs[0].expReady = 4'b0010;
    vecs[1].valid = 4'b1111; vecs[1].expReady = 4'b0100;
    vecs[2].valid = 4'b1111; vecs[2].expReady = 4'b1000;
    vecs[3].valid = 4'b1111; vecs[3].expReady = 4'b0001;
    vecs[4].valid = 4'b1001; vecs[4].expReady = 4'b1000;
    vecs[5].valid = 4'b0110; vecs[5].expReady = 4'b0010;
    vecs[6].valid = 4'b0011; vecs[6].expReady = 4'b0001;
    vecs[7].valid = 4'b0100; vecs[7].expReady = 4'b0100;
`endif
    for (int k = 0; k < 8; k++) begin
      vecs[k].data = {8'h40 + 8'(k), 8'h30 + 8'(k), 8'h20 + 8'(k), 8'h10 + 8'(k)};
    end

    // Reset state
    reset_n = 1'b0;
    applyStimulus(4'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("rst_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, tx_wr_en}, 32'd0);
    checkOutput("rst_din", {24'd0, tx_din}, 32'd0);
    checkOutput("rst_grant", {30'd0, grant_id}, 32'd0);
    checkOutput("rst_active", {31'd0, active}, 32'd0);
    checkOutput("rst_err", {31'd0, tx_err}, 32'd0);
    reset_n = 1'b1;

    // First byte from requester 0, granted in the same cycle
    driveAndExpect(4'b0001, 32'h0000_00A5, 1'b0, 4'b0001, "first_ready");
    finishTransfer(10);

    // Arbitration table
    for (int k = 0; k < 8; k++) begin
      driveAndExpect(vecs[k].valid, vecs[k].data, 1'b0, vecs[k].expReady, $sformatf("vec%0d_ready", k));
      finishTransfer(10);
    end

    // Transmitter never goes busy
    driveAndExpect(4'b0001, 32'h0000_003C, 1'b0, 4'b0001, "timeout_ready");
    @(posedge clock);
    @(negedge clock);
    applyStimulus(4'd0, 32'h0000_003C, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checkOutput($sformatf("timeout_active%0d", k), {31'd0, active}, 32'd1);
      checkOutput($sformatf("timeout_err_early%0d", k), {31'd0, tx_err}, 32'd0);
    end
    @(negedge clock);
    checkOutput("timeout_idle", {31'd0, active}, 32'd0);
    checkOutput("timeout_err", {31'd0, tx_err}, 32'd1);

    // Busy in IDLE blocks grants until it falls
    @(negedge clock);
    applyStimulus(4'b0100, 32'h00D2_0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("busy_block_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clock);
    end
    driveAndExpect(4'b0100, 32'h00D2_0000, 1'b0, 4'b0100, "busy_release_ready");
    finishTransfer(2);
    checkOutput("err_sticky", {31'd0, tx_err}, 32'd1);

    // Requester 0 withdraws before acceptance and must never be granted
    @(negedge clock);
    applyStimulus(4'b0001, 32'h0000_7711, 1'b1);
    repeat (2) @(negedge clock);
    driveAndExpect(4'b0010, 32'h0000_7711, 1'b0, 4'b0010, "withdraw_ready");
    finishTransfer(2);

    // Reset pulse while in WAIT_DONE
    driveAndExpect(4'b1000, 32'hC300_0000, 1'b0, 4'b1000, "wd_ready");
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    applyStimulus(4'b1000, 32'hC300_0000, 1'b1);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("wd_rst_din", {24'd0, tx_din}, 32'd0);
    checkOutput("wd_rst_grant", {30'd0, grant_id}, 32'd0);
    checkOutput("wd_rst_active", {31'd0, active}, 32'd0);
    checkOutput("wd_rst_wr_en", {31'd0, tx_wr_en}, 32'd0);
    checkOutput("wd_rst_err", {31'd0, tx_err}, 32'd0);
    applyStimulus(4'b1111, 32'h4433_2211, 1'b0);
    #1;
    checkOutput("wd_rst_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(4'd0, 32'h4433_2211, 1'b0);
    repeat (3) @(negedge clock);
    driveAndExpect(4'b1111, 32'h4433_2211, 1'b0, 4'b0001, "post_reset_ready");
    finishTransfer(2);

    repeat (3) @(negedge clock);
    checkOutput("sb_empty", sbQueue.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
